// File: rtl/fpu_bus_pkg.sv
// fpu_bus_pkg: shared types and bus constants for the FPU bus initiator.
package fpu_bus_pkg;
  typedef enum logic [2:0] {OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MULT = 3'd2} op_e;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_TIMEOUT = 2'b01, ST_ILLEGAL_OP = 2'b10} status_e;
  typedef enum logic [2:0] {S_IDLE, S_WR_A, S_WR_B, S_WAIT, S_RD, S_DONE} state_e;
  localparam logic [5:0] ADDR_OPA_BASE = 6'h00;
  localparam logic [5:0] ADDR_OPB = 6'h01;
  localparam logic [5:0] ADDR_RESULT = 6'h0C;
  localparam logic [5:0] ADDR_BUSY = 6'h10;
  localparam logic [1:0] STB_NONE = 2'b11;
  localparam logic [1:0] STB_HALF = 2'b01;
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_MULT;
  endfunction
endpackage

// File: rtl/fpu_bus_wdog.sv
// fpu_bus_wdog: clearable WAIT-cycle counter with terminal count at TIMEOUT_CYCLES-1.
module fpu_bus_wdog #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
  assign tc = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/fpu_bus_initiator.sv
// fpu_bus_initiator: runs one FPU job (write A, write B, wait, read result) as a Moore FSM.
// Optional BUSY_POLL_EN: WAIT polls the busy register instead of watching data_ready.
module fpu_bus_initiator
  import fpu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [2:0]  job_op,
  input  logic [15:0] job_a,
  input  logic [15:0] job_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [1:0]  res_status,
  output logic [5:0]  address,
  output logic [31:0] data_out,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_in,
  input  logic        data_ready
);
  state_e state, next;
  status_e status_q;
  logic [2:0] op_q;
  logic [15:0] a_q, b_q, data_q;
  logic [CNT_W-1:0] cnt;
  logic tc, guard, go, accept, unused_ok;
  fpu_bus_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_wdog (
    .clk(clk), .rst_n(rst_n), .clr(state == S_WR_B), .en(state == S_WAIT), .cnt(cnt), .tc(tc)
  );
  // the first WAIT cycle ignores completion so a stale flag cannot trigger a read
  assign guard = cnt == '0;
  assign accept = job_valid && job_ready;
`ifdef BUSY_POLL_EN
  assign go = ~data_in[0];
`else
  assign go = data_ready;
`endif
  assign unused_ok = ^{data_in[31:16], data_ready};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      S_IDLE: next = accept ? (op_legal(job_op) ? S_WR_A : S_DONE) : S_IDLE;
      S_WR_A: next = S_WR_B;
      S_WR_B: next = S_WAIT;
      S_WAIT: next = (!guard && go) ? S_RD : tc ? S_DONE : S_WAIT;
      S_RD:   next = S_DONE;
      S_DONE: next = res_ready ? S_IDLE : S_DONE;
      default: next = S_IDLE;
    endcase
  end
  always_comb begin
    job_ready = state == S_IDLE;
    res_valid = state == S_DONE;
    address = '0;
    data_out = '0;
    data_write_n = STB_NONE;
    data_read_n = STB_NONE;
    case (state)
      S_WR_A: begin
        address = ADDR_OPA_BASE | {1'b0, op_q, 2'b00};
        data_out = {16'h0, a_q};
        data_write_n = STB_HALF;
      end
      S_WR_B: begin
        address = ADDR_OPB;
        data_out = {16'h0, b_q};
        data_write_n = STB_HALF;
      end
`ifdef BUSY_POLL_EN
      S_WAIT: begin
        address = guard ? '0 : ADDR_BUSY;
        data_read_n = guard ? STB_NONE : STB_HALF;
      end
`endif
      S_RD: begin
        address = ADDR_RESULT;
        data_read_n = STB_HALF;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
      status_q <= ST_OK;
    end else begin
      if (state == S_IDLE && accept) begin
        op_q <= job_op;
        a_q <= job_a;
        b_q <= job_b;
        data_q <= '0;
        status_q <= op_legal(job_op) ? ST_OK : ST_ILLEGAL_OP;
      end
      if (state == S_WAIT && next == S_DONE) status_q <= ST_TIMEOUT;
      if (state == S_RD) begin
        data_q <= data_in[15:0];
        status_q <= ST_OK;
      end
    end
  assign res_data = data_q;
  assign res_status = status_q;
endmodule

// File: tb/tb_fpu_bus_initiator.sv
// tb_fpu_bus_initiator: directed bench with a small FPU peripheral model on the bus.
`timescale 1ns/1ps
module tb_fpu_bus_initiator;
  logic clk = 0, rst_n, job_valid, job_ready, res_valid, res_ready, data_ready;
  logic [2:0] job_op;
  logic [15:0] job_a, job_b, res_data;
  logic [1:0] res_status, data_write_n, data_read_n;
  logic [5:0] address;
  logic [31:0] data_out, data_in;
  int passed = 0, total = 0;
  logic [5:0] log_addr [0:255];
  logic [31:0] log_data [0:255];
  int wr_cnt = 0, rd_cnt = 0, a_cnt = 0, since_b = 0, rdy_dly = -1, stale_ref = 0;
  bit b_seen = 0, stale_en = 0;
  logic [15:0] periph_res = 16'h0;
  int lat, w0, r0;

  fpu_bus_initiator dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready), .job_op(job_op),
    .job_a(job_a), .job_b(job_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_status(res_status), .address(address), .data_out(data_out),
    .data_write_n(data_write_n), .data_read_n(data_read_n), .data_in(data_in),
    .data_ready(data_ready)
  );

  always #5 clk = ~clk;

  // peripheral model: logs bus traffic and raises data_ready rdy_dly cycles into WAIT
  always @(posedge clk) begin
    if (data_write_n == 2'b01) begin
      log_addr[wr_cnt] <= address;
      log_data[wr_cnt] <= data_out;
      wr_cnt <= wr_cnt + 1;
      if (address == 6'h01) begin
        b_seen <= 1;
        since_b <= 0;
      end else begin
        b_seen <= 0;
        a_cnt <= a_cnt + 1;
      end
    end else if (b_seen) since_b <= since_b + 1;
    if (data_read_n == 2'b01) rd_cnt <= rd_cnt + 1;
  end
  assign data_ready = (stale_en && a_cnt == stale_ref) || (b_seen && rdy_dly >= 0 && since_b >= rdy_dly);
  assign data_in = (data_read_n == 2'b01 && address == 6'h0C) ? {16'hBEEF, periph_res} : 32'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic run_job(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, output int l);
    @(negedge clk);
    job_op = op; job_a = a; job_b = b; job_valid = 1;
    @(negedge clk);
    job_valid = 0;
    l = 1;
    while (!res_valid && l < 200) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic take_result();
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("idle_job_ready", 32'(job_ready), 32'd1);
    chk("idle_res_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 0; job_valid = 0; job_op = 0; job_a = 0; job_b = 0; res_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_status", 32'(res_status), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_write_n", 32'(data_write_n), 32'd3);
    chk("rst_read_n", 32'(data_read_n), 32'd3);
    rst_n = 1;

    w0 = wr_cnt; r0 = rd_cnt; periph_res = 16'h4200; rdy_dly = 0;
    run_job(3'd0, 16'h3C00, 16'h4000, lat);
    chk("add_latency", 32'(lat), 32'd6);
    chk("add_writes", 32'(wr_cnt - w0), 32'd2);
    chk("add_addr_a", 32'(log_addr[w0]), 32'h00);
    chk("add_data_a", log_data[w0], 32'h0000_3C00);
    chk("add_addr_b", 32'(log_addr[w0+1]), 32'h01);
    chk("add_data_b", log_data[w0+1], 32'h0000_4000);
    chk("add_reads", 32'(rd_cnt - r0), 32'd1);
    chk("add_res", 32'(res_data), 32'h4200);
    chk("add_status", 32'(res_status), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", 32'(res_data), 32'h4200);
      chk("hold_status", 32'(res_status), 32'd0);
      chk("hold_job_ready", 32'(job_ready), 32'd0);
      @(negedge clk);
    end
    take_result();

    w0 = wr_cnt; r0 = rd_cnt; periph_res = 16'h4600; rdy_dly = 3;
    run_job(3'd2, 16'h4000, 16'h4200, lat);
    chk("mult_latency", 32'(lat), 32'd8);
    chk("mult_addr_a", 32'(log_addr[w0]), 32'h08);
    chk("mult_data_a", log_data[w0], 32'h0000_4000);
    chk("mult_data_b", log_data[w0+1], 32'h0000_4200);
    chk("mult_reads", 32'(rd_cnt - r0), 32'd1);
    chk("mult_res", 32'(res_data), 32'h4600);
    chk("mult_status", 32'(res_status), 32'd0);
    take_result();

    w0 = wr_cnt; r0 = rd_cnt; periph_res = 16'h4000; rdy_dly = 1;
    stale_ref = a_cnt; stale_en = 1;
    run_job(3'd1, 16'h4200, 16'h3C00, lat);
    stale_en = 0;
    chk("sub_latency", 32'(lat), 32'd6);
    chk("sub_addr_a", 32'(log_addr[w0]), 32'h04);
    chk("sub_reads", 32'(rd_cnt - r0), 32'd1);
    chk("sub_res", 32'(res_data), 32'h4000);
    chk("sub_status", 32'(res_status), 32'd0);
    take_result();

    w0 = wr_cnt; r0 = rd_cnt;
    run_job(3'b101, 16'h1234, 16'h5678, lat);
    chk("ill_latency", 32'(lat), 32'd1);
    chk("ill_status", 32'(res_status), 32'd2);
    chk("ill_res", 32'(res_data), 32'd0);
    chk("ill_writes", 32'(wr_cnt - w0), 32'd0);
    chk("ill_reads", 32'(rd_cnt - r0), 32'd0);
    take_result();

    w0 = wr_cnt; r0 = rd_cnt; periph_res = 16'h7777; rdy_dly = -1;
    run_job(3'd0, 16'h3C00, 16'h3C00, lat);
    chk("to_latency", 32'(lat), 32'd67);
    chk("to_status", 32'(res_status), 32'd1);
    chk("to_res", 32'(res_data), 32'd0);
    chk("to_writes", 32'(wr_cnt - w0), 32'd2);
    chk("to_reads", 32'(rd_cnt - r0), 32'd0);
    take_result();

    @(negedge clk);
    job_op = 3'd0; job_a = 16'h3C00; job_b = 16'h4000; job_valid = 1;
    @(negedge clk);
    job_valid = 0;
    repeat (3) @(negedge clk);
    chk("wait_job_ready", 32'(job_ready), 32'd0);
    #2 rst_n = 0;
    #1;
    chk("rstw_write_n", 32'(data_write_n), 32'd3);
    chk("rstw_read_n", 32'(data_read_n), 32'd3);
    chk("rstw_job_ready", 32'(job_ready), 32'd1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rstw_release_ready", 32'(job_ready), 32'd1);
    chk("rstw_release_valid", 32'(res_valid), 32'd0);

    job_valid = 1;
    @(negedge clk);
    job_valid = 0;
    chk("wra_write_n", 32'(data_write_n), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rsta_write_n", 32'(data_write_n), 32'd3);
    chk("rsta_address", 32'(address), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rsta_release_ready", 32'(job_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
